i2c_scl_tick_gen: RTL and testbench



---
 rtl/i2c_scl_tick_gen.sv | 132 +++++++++++++
 tb/tb_i2c_scl_tick_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_tick_gen.sv
// i2c_scl_tick_gen: oscillator settle gate plus quarter-period SCL tick generator with stretch freeze and bit-aligned divisor reload
module i2c_scl_tick_gen #(
    parameter int DIV_W         = 16,
    parameter int DEFAULT_DIV   = 125,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    input  logic             run,
    input  logic             stretch,
    output logic             ready,
    output logic             busy,
    output logic             tick,
    output logic [1:0]       phase
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {SETTLE, IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, div_pend_q, div_pend_d;
    logic [DIV_W-1:0] load_val, pend_next;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             pend_valid_q, pend_valid_d, tick_q, tick_d, ack_q, ack_d;
    logic             load_req, pend_any, settle_done, cnt_end;

    // A load is accepted only when no ack was just issued, so a request still held during its ack is not taken twice.
    assign load_req    = div_load && !ack_q;
    assign load_val    = (div_in == '0) ? DIV_W'(1) : div_in;
    assign pend_any    = load_req || pend_valid_q;
    assign pend_next   = load_req ? load_val : div_pend_q;
    assign settle_done = settle_cnt_q == SW'(SETTLE_CYCLES - 1);
    assign cnt_end     = cnt_q == div_cur_q - DIV_W'(1);

    // State and datapath registers, all cleared back to the settle condition on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
            cnt_q        <= '0;
            phase_q      <= '0;
            div_cur_q    <= DIV_W'(DEFAULT_DIV);
            div_pend_q   <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            div_cur_q    <= div_cur_d;
            div_pend_q   <= div_pend_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            ack_q        <= ack_d;
        end
    end

    // Next-state selection; dropping run wins over stretch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE: state_d = settle_done ? IDLE : SETTLE;
            IDLE:   state_d = run ? RUN : IDLE;
            RUN:    state_d = !run ? IDLE : (stretch ? HOLD : RUN);
            HOLD:   state_d = !run ? IDLE : (stretch ? HOLD : RUN);
        endcase
    end

    // Counter, phase and divisor updates; a pending divisor lands only on the 3->0 tick or when run drops.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        div_cur_d    = div_cur_q;
        div_pend_d   = div_pend_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;
        ack_d        = 1'b0;
        case (state_q)
            SETTLE: settle_cnt_d = settle_done ? settle_cnt_q : settle_cnt_q + SW'(1);
            IDLE: begin
                cnt_d   = '0;
                phase_d = '0;
                if (load_req) begin
                    div_cur_d = load_val;
                    ack_d     = 1'b1;
                end
            end
            RUN, HOLD: begin
                if (!run) begin
                    cnt_d        = '0;
                    phase_d      = '0;
                    pend_valid_d = 1'b0;
                    if (pend_any) begin
                        div_cur_d = pend_next;
                        ack_d     = 1'b1;
                    end
                end else begin
                    div_pend_d   = pend_next;
                    pend_valid_d = pend_any;
                    if (state_q == RUN && !stretch) begin
                        cnt_d = cnt_end ? '0 : cnt_q + DIV_W'(1);
                        if (cnt_end) begin
                            tick_d  = 1'b1;
                            phase_d = phase_q + 2'd1;
                            if (phase_q == 2'd3 && pend_any) begin
                                div_cur_d    = pend_next;
                                ack_d        = 1'b1;
                                pend_valid_d = 1'b0;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // Outputs decode directly from registers.
    always_comb begin
        ready   = state_q != SETTLE;
        busy    = state_q == RUN || state_q == HOLD;
        tick    = tick_q;
        phase   = phase_q;
        div_ack = ack_q;
    end
endmodule

// File: tb/tb_i2c_scl_tick_gen.sv
// tb_i2c_scl_tick_gen: countdown-based reference model compared every cycle plus directed timing checks
module tb_i2c_scl_tick_gen;
    localparam int SETTLE = 16;
    localparam int DEFDIV = 125;

    logic        CLK = 0, RST = 1;
    logic [15:0] div_in = 0;
    logic        div_load = 0, run = 0, stretch = 0;
    logic        div_ack, ready, busy, tick;
    logic [1:0]  phase;

    int tests = 0, fails = 0, cyc = 0, e0, r0, rel, ld;
    int tick_cyc[$], tick_ph[$], ack_cyc[$];

    int m_edges, m_div, m_left, m_phase, m_pend;
    bit m_ready, m_busy, m_hold, m_tick, m_ack, m_pv;

    i2c_scl_tick_gen #(.DIV_W(16), .DEFAULT_DIV(DEFDIV), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .RST(RST), .div_in(div_in), .div_load(div_load), .div_ack(div_ack),
        .run(run), .stretch(stretch), .ready(ready), .busy(busy), .tick(tick), .phase(phase)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit req, nt, na;
        int cl;
        req = div_load && !m_ack;
        cl  = (div_in == 0) ? 1 : int'(div_in);
        nt  = 0;
        na  = 0;
        if (!m_ready) begin
            m_edges++;
            if (m_edges == SETTLE) m_ready = 1;
        end else if (!m_busy) begin
            if (req) begin m_div = cl; na = 1; end
            if (run) begin m_busy = 1; m_hold = 0; m_left = m_div; m_phase = 0; end
        end else begin
            if (req) begin m_pend = cl; m_pv = 1; end
            if (!run) begin
                if (m_pv) begin m_div = m_pend; na = 1; m_pv = 0; end
                m_busy = 0;
                m_phase = 0;
            end else if (m_hold) begin
                if (!stretch) m_hold = 0;
            end else if (stretch) begin
                m_hold = 1;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    nt = 1;
                    m_phase = (m_phase + 1) % 4;
                    if (m_phase == 0 && m_pv) begin m_div = m_pend; na = 1; m_pv = 0; end
                    m_left = m_div;
                end
            end
        end
        m_tick = nt;
        m_ack  = na;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_edges = 0; m_ready = 0; m_busy = 0; m_hold = 0; m_tick = 0; m_ack = 0;
            m_div = DEFDIV; m_left = 0; m_phase = 0; m_pv = 0; m_pend = 0;
        end else begin
            model_step();
        end
        #1;
        check("ready", ready, m_ready);
        check("busy", busy, m_busy);
        check("tick", tick, m_tick);
        check("phase", phase, m_phase);
        check("div_ack", div_ack, m_ack);
        if (tick) begin tick_cyc.push_back(cyc); tick_ph.push_back(phase); end
        if (div_ack) ack_cyc.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_ticks(input int n, input int limit, input string nm);
        int k = 0;
        while (tick_cyc.size() < n && k < limit) begin @(negedge CLK); k++; end
        check(nm, tick_cyc.size() >= n, 1);
    endtask

    task automatic wait_ack(input int limit, input string nm);
        int k = 0;
        while (!div_ack && k < limit) begin @(negedge CLK); k++; end
        check(nm, div_ack, 1);
    endtask

    task automatic clear_logs();
        tick_cyc.delete(); tick_ph.delete(); ack_cyc.delete();
    endtask

    task automatic idle_load(input int v);
        run = 0;
        step(2);
        div_in = 16'(v);
        div_load = 1;
        wait_ack(10, "idle_ack_timeout");
        div_load = 0;
        step(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", tick, 0);
        check("rst_phase", phase, 0);
        check("rst_ack", div_ack, 0);
        RST = 0;
        r0 = cyc;
        clear_logs();
        step(3);
        run = 1; div_load = 1; div_in = 7;
        step(5);
        run = 0; div_load = 0;
        while (cyc < r0 + SETTLE - 1) step(1);
        check("settle_ready_edge15", ready, 0);
        step(1);
        check("settle_ready_edge16", ready, 1);
        check("settle_no_ticks", tick_cyc.size(), 0);
        check("settle_no_acks", ack_cyc.size(), 0);

        clear_logs();
        run = 1;
        e0 = cyc + 1;
        wait_ticks(9, 1200, "def_tick_timeout");
        for (int i = 0; i < 8; i++) begin
            check("def_tick_time", tick_cyc[i], e0 + 125 * (i + 1));
            check("def_tick_phase", tick_ph[i], (i + 1) % 4);
        end
        check("def_phase_now", phase, 1);
        div_in = 4;
        div_load = 1;
        wait_ack(600, "run_ack_timeout");
        div_load = 0;
        check("run_ack_edge", ack_cyc.size() > 0 ? ack_cyc[0] : -1, e0 + 1500);
        wait_ticks(14, 50, "reload_tick_timeout");
        check("pre_reload_gap1", tick_cyc[10] - tick_cyc[9], 125);
        check("pre_reload_gap2", tick_cyc[11] - tick_cyc[10], 125);
        check("wrap_tick_phase", tick_ph[11], 0);
        check("post_reload_gap", tick_cyc[12] - tick_cyc[11], 4);
        check("post_reload_tick", tick_cyc[13], e0 + 1508);

        idle_load(10);
        clear_logs();
        run = 1;
        e0 = cyc + 1;
        step(7);
        stretch = 1;
        step(20);
        stretch = 0;
        rel = cyc + 1;
        wait_ticks(1, 30, "stretch_tick_timeout");
        check("stretch_tick_time", tick_cyc[0], e0 + 31);
        check("stretch_release_gap", tick_cyc[0] - rel, 4);
        check("stretch_tick_phase", tick_ph[0], 1);

        run = 0;
        step(2);
        ack_cyc.delete();
        div_in = 0;
        div_load = 1;
        ld = cyc + 1;
        wait_ack(5, "zero_ack_timeout");
        div_load = 0;
        check("zero_ack_edge", ack_cyc.size() > 0 ? ack_cyc[0] : -1, ld);
        step(1);
        clear_logs();
        run = 1;
        e0 = cyc + 1;
        step(6);
        check("div1_tick_count", tick_cyc.size() >= 5, 1);
        for (int i = 0; i < 5 && i < tick_cyc.size(); i++) begin
            check("div1_tick_time", tick_cyc[i], e0 + 1 + i);
            check("div1_tick_phase", tick_ph[i], (i + 1) % 4);
        end

        idle_load(8);
        clear_logs();
        run = 1;
        e0 = cyc + 1;
        wait_ticks(2, 40, "drop_setup_timeout");
        check("drop_phase2", phase, 2);
        div_in = 3;
        div_load = 1;
        step(3);
        ack_cyc.delete();
        run = 0;
        step(1);
        div_load = 0;
        check("drop_busy", busy, 0);
        check("drop_phase", phase, 0);
        check("drop_ack", div_ack, 1);
        check("drop_ack_edge", ack_cyc.size() > 0 ? ack_cyc[0] : -1, cyc);
        clear_logs();
        step(20);
        check("drop_no_ticks", tick_cyc.size(), 0);
        run = 1;
        e0 = cyc + 1;
        wait_ticks(2, 20, "drop_newdiv_timeout");
        check("drop_newdiv_t0", tick_cyc[0], e0 + 3);
        check("drop_newdiv_t1", tick_cyc[1], e0 + 6);

        step(4);
        RST = 1;
        #1;
        check("mid_rst_ready", ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_ack", div_ack, 0);
        step(2);
        RST = 0;
        r0 = cyc;
        clear_logs();
        wait_ticks(1, 200, "post_rst_tick_timeout");
        check("post_rst_default_div", tick_cyc[0], r0 + SETTLE + 1 + DEFDIV);
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
